// File: rtl/dcache_nway.sv
// N-way set-associative, write-back, write-allocate data cache, one word per line.
// Hits complete in the request cycle; misses stall through an optional write-back and a fill.
module dcache_nway #(
    parameter int unsigned WD   = 32,
    parameter int unsigned WAYS = 2,
    parameter int unsigned SETS = 8,
    parameter int unsigned CW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [WD-1:0] cpu_addr,
    input  logic [WD-1:0] cpu_wdata,
    output logic [WD-1:0] cpu_rdata,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [WD-1:0] mem_addr,
    output logic [WD-1:0] mem_wdata,
    input  logic [WD-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [CW-1:0] hit_count,
    output logic [CW-1:0] miss_count
);

    localparam int unsigned IB = $clog2(SETS);
    localparam int unsigned TW = WD - IB - 2;
    localparam int unsigned VW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {StIdle, StWriteback, StFill} state_e;

    state_e state_q, state_d;

    logic [SETS-1:0] valid_q [WAYS];
    logic [SETS-1:0] dirty_q [WAYS];
    logic [TW-1:0]   tag_q   [WAYS][SETS];
    logic [WD-1:0]   data_q  [WAYS][SETS];
    logic [VW-1:0]   ptr_q   [SETS];

    logic [VW-1:0] vic_way_q;
    logic [IB-1:0] vic_idx_q;
    logic [TW-1:0] vic_tag_q;
    logic [CW-1:0] hit_count_q, miss_count_q;

    logic          req;
    logic [IB-1:0] idx;
    logic [TW-1:0] tag;
    logic          hit;
    logic [VW-1:0] hit_way;
    logic          vic_found;
    logic [VW-1:0] vic_way;
    logic          hit_now, miss_start, wb_done, fill_done;
    logic          unused_addr;

    assign req         = cpu_read | cpu_write;
    assign idx         = cpu_addr[IB+1:2];
    assign tag         = cpu_addr[WD-1:IB+2];
    assign unused_addr = ^cpu_addr[1:0];
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!hit && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = VW'(w);
            end
        end
    end

    // Lowest invalid way wins; otherwise fall back to the set's round-robin pointer.
    always_comb begin
        vic_found = 1'b0;
        vic_way   = (WAYS > 1) ? ptr_q[idx] : '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!vic_found && !valid_q[w][idx]) begin
                vic_found = 1'b1;
                vic_way   = VW'(w);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        hit_now    = 1'b0;
        miss_start = 1'b0;
        wb_done    = 1'b0;
        fill_done  = 1'b0;
        stall      = (state_q != StIdle) | (req & ~hit);
        unique case (state_q)
            StIdle: begin
                if (req && hit) begin
                    hit_now = 1'b1;
                end else if (req) begin
                    miss_start = 1'b1;
                    if (valid_q[vic_way][idx] && dirty_q[vic_way][idx]) begin
                        state_d = StWriteback;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StWriteback: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vic_tag_q, vic_idx_q, 2'b00};
                mem_wdata = data_q[vic_way_q][vic_idx_q];
                if (mem_ack) begin
                    wb_done = 1'b1;
                    state_d = StFill;
                end
            end
            StFill: begin
                mem_req  = 1'b1;
                mem_addr = {tag, vic_idx_q, 2'b00};
                if (mem_ack) begin
                    fill_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        cpu_rdata = (hit_now && !cpu_write) ? data_q[hit_way][idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            vic_way_q    <= '0;
            vic_idx_q    <= '0;
            vic_tag_q    <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int w = 0; w < int'(WAYS); w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < int'(SETS); s++) begin
                ptr_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (hit_now) begin
                hit_count_q <= hit_count_q + CW'(1);
                if (cpu_write) begin
                    dirty_q[hit_way][idx] <= 1'b1;
                end
            end
            if (miss_start) begin
                miss_count_q <= miss_count_q + CW'(1);
                vic_way_q    <= vic_way;
                vic_idx_q    <= idx;
                vic_tag_q    <= tag_q[vic_way][idx];
            end
            if (wb_done) begin
                dirty_q[vic_way_q][vic_idx_q] <= 1'b0;
            end
            if (fill_done) begin
                valid_q[vic_way_q][vic_idx_q] <= 1'b1;
                dirty_q[vic_way_q][vic_idx_q] <= 1'b0;
                if (WAYS > 1) begin
                    ptr_q[vic_idx_q] <= ptr_q[vic_idx_q] + VW'(1);
                end
            end
        end
    end

    // Tag and data arrays carry no reset; validity alone decides whether they are used.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (hit_now && cpu_write) begin
                data_q[hit_way][idx] <= cpu_wdata;
            end
            if (fill_done) begin
                data_q[vic_way_q][vic_idx_q] <= mem_rdata;
                tag_q[vic_way_q][vic_idx_q]  <= tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// Scoreboard bench for dcache_nway: stimulus queues expected memory transactions and CPU
// completions; a monitor pops and compares them as the DUT presents them.
module tb_dcache_nway;

    localparam int WD = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_read = 1'b0, cpu_write = 1'b0;
    logic [WD-1:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic          stall, mem_req, mem_we, mem_ack;
    logic [WD-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [CW-1:0] hit_count, miss_count;

    dcache_nway #(.WD(WD), .WAYS(2), .SETS(8), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        bit          we;
        bit          chk_data;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_model [logic [31:0]];
    int          ack_delay = 3;
    bit          ack_block = 0;
    bit          force_ack = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void exp_mem(bit we, logic [31:0] addr, bit chk, logic [31:0] data);
        exp_t e;
        e.is_mem = 1'b1; e.we = we; e.addr = addr; e.chk_data = chk; e.data = data;
        sbq.push_back(e);
    endfunction

    function automatic void exp_cpu(bit chk, logic [31:0] data);
        exp_t e;
        e.is_mem = 1'b0; e.we = 1'b0; e.addr = '0; e.chk_data = chk; e.data = data;
        sbq.push_back(e);
    endfunction

    // Backing memory: acks ack_delay cycles into each transaction; force_ack injects a stray ack.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end else if (mem_req && !ack_block) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    cnt     = 0;
                    mem_ack = 1'b1;
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: a new memory transaction or a completed CPU request pops the scoreboard.
    initial begin
        exp_t        e;
        bit          prev_req, prev_we;
        logic [31:0] prev_addr;
        prev_req = 0; prev_we = 0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (mem_req && (!prev_req || mem_we != prev_we || mem_addr != prev_addr)) begin
                if (sbq.size() == 0 || !sbq[0].is_mem) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem actual we=%0b addr=%h required none", mem_we,
                             mem_addr);
                end else begin
                    e = sbq.pop_front();
                    check("mem_we", 32'(mem_we), 32'(e.we));
                    check("mem_addr", mem_addr, e.addr);
                    if (e.chk_data) check("mem_wdata", mem_wdata, e.data);
                end
            end
            prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr;
            if (!rst && (cpu_read || cpu_write) && !stall) begin
                if (sbq.size() == 0 || sbq[0].is_mem) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cpu actual addr=%h required pending item", cpu_addr);
                end else begin
                    e = sbq.pop_front();
                    if (e.chk_data) check("cpu_rdata", cpu_rdata, e.data);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_hit_count", 32'(hit_count), 32'h0);
        check("rst_miss_count", 32'(miss_count), 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        tick();
    endtask

    task automatic req(bit rd, bit wr, logic [31:0] addr, logic [31:0] wd, bit exp_stall,
                       string name);
        int n;
        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
        @(negedge clk);
        check({name, "_stall"}, 32'(stall), 32'(exp_stall));
        n = 0;
        while (stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual stall=1 required stall=0", name);
        end
        tick();
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic counts(string name, int hits, int misses);
        check({name, "_hits"}, 32'(hit_count), 32'(hits));
        check({name, "_misses"}, 32'(miss_count), 32'(misses));
    endtask

    initial begin
        // Cold read
        do_reset();
        mem_model[32'h40] = 32'hDEAD_BEEF;
        exp_mem(0, 32'h40, 0, '0);
        exp_cpu(1, 32'hDEAD_BEEF);
        req(1, 0, 32'h40, '0, 1, "cold_read");
        counts("cold", 1, 1);

        // Write hit then dirty eviction of way 0
        mem_model[32'h140] = 32'h1400_0001;
        mem_model[32'h240] = 32'h2400_0002;
        exp_cpu(0, '0);
        req(0, 1, 32'h40, 32'h11, 0, "write_hit");
        exp_cpu(1, 32'h11);
        req(1, 0, 32'h40, '0, 0, "read_after_write");
        exp_mem(0, 32'h140, 0, '0);
        exp_cpu(1, 32'h1400_0001);
        req(1, 0, 32'h140, '0, 1, "fill_140");
        exp_mem(1, 32'h40, 1, 32'h11);
        exp_mem(0, 32'h240, 0, '0);
        exp_cpu(1, 32'h2400_0002);
        req(1, 0, 32'h240, '0, 1, "evict_dirty");
        counts("evict", 5, 3);
        check("wb_model", mem_model[32'h40], 32'h11);

        // Victim round-robin
        do_reset();
        mem_model[32'h40]  = 32'hA000_0000;
        mem_model[32'h140] = 32'hA000_0001;
        mem_model[32'h240] = 32'hA000_0002;
        mem_model[32'h340] = 32'hA000_0003;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'h40 + 32'(i) * 32'h100;
            exp_mem(0, a, 0, '0);
            exp_cpu(1, 32'hA000_0000 + 32'(i));
            req(1, 0, a, '0, 1, "rr_fill");
        end
        exp_cpu(1, 32'hA000_0002);
        req(1, 0, 32'h240, '0, 0, "rr_hit_240");
        exp_cpu(1, 32'hA000_0003);
        req(1, 0, 32'h340, '0, 0, "rr_hit_340");
        exp_mem(0, 32'h40, 0, '0);
        exp_cpu(1, 32'hA000_0000);
        req(1, 0, 32'h40, '0, 1, "rr_miss_40");
        exp_cpu(1, 32'hA000_0003);
        req(1, 0, 32'h340, '0, 0, "rr_keep_340");
        exp_mem(0, 32'h240, 0, '0);
        exp_cpu(1, 32'hA000_0002);
        req(1, 0, 32'h240, '0, 1, "rr_lost_240");
        counts("rr", 9, 6);

        // Read/write priority: treated as a single write hit
        exp_cpu(0, '0);
        req(1, 1, 32'h40, 32'h5A, 0, "rw_prio");
        counts("prio", 10, 6);
        exp_cpu(1, 32'h5A);
        req(1, 0, 32'h40, '0, 0, "prio_readback");
        exp_mem(1, 32'h40, 1, 32'h5A);
        exp_mem(0, 32'h140, 0, '0);
        exp_cpu(1, 32'hA000_0001);
        req(1, 0, 32'h140, '0, 1, "prio_dirty_evict");
        counts("prio_evict", 12, 7);

        // Reset mid-FILL with a stray ack during reset
        mem_model[32'h340] = 32'h0BAD_F00D;
        ack_block = 1;
        exp_mem(0, 32'h340, 0, '0);
        cpu_read = 1'b1; cpu_addr = 32'h340;
        tick();
        tick();
        rst = 1'b1; force_ack = 1;
        tick();
        rst = 1'b0; force_ack = 0; cpu_read = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", 32'(mem_req), 32'h0);
        check("midrst_stall", 32'(stall), 32'h0);
        counts("midrst", 0, 0);
        ack_block = 0;
        tick();
        exp_mem(0, 32'h340, 0, '0);
        exp_cpu(1, 32'h0BAD_F00D);
        req(1, 0, 32'h340, '0, 1, "midrst_reread");
        counts("midrst_reread", 1, 1);

        // Counter wrap at CW=4
        do_reset();
        mem_model[32'h40] = 32'h0000_C0DE;
        exp_mem(0, 32'h40, 0, '0);
        exp_cpu(1, 32'h0000_C0DE);
        req(1, 0, 32'h40, '0, 1, "wrap_fill");
        for (int i = 0; i < 14; i++) begin
            exp_cpu(1, 32'h0000_C0DE);
            req(1, 0, 32'h40, '0, 0, "wrap_hit");
        end
        counts("wrap15", 15, 1);
        exp_cpu(1, 32'h0000_C0DE);
        req(1, 0, 32'h40, '0, 0, "wrap_last");
        counts("wrap16", 0, 1);

        tick();
        tick();
        check("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
